reg_univ: RTL and testbench



---
 rtl/reg_univ_pkg.sv | 28 ++
 rtl/reg_univ_next.sv | 92 +++++++++
 rtl/reg_univ.sv | 74 +++++++
 tb/tb_reg_univ.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_univ_pkg.sv
// reg_univ_pkg -- shared definitions for the universal register.
//
// Contents:
//   MODE_W            width of the operation code
//   mode_t            operation code type
//   MODE_HOLD..DEC    the eight operation codes (all eight are legal)
//   mode_is_arith()   helper: true for the two arithmetic codes (INC/DEC)
package reg_univ_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_INC  = 3'b110;
  localparam mode_t MODE_DEC  = 3'b111;

  // The arithmetic codes are exactly those with both upper bits set.
  function automatic logic mode_is_arith(input mode_t m);
    return (m[2:1] == 2'b11);
  endfunction

endpackage : reg_univ_pkg

// File: rtl/reg_univ_next.sv
// reg_univ_next -- purely combinational next-state logic of the universal
// register. Holds no state; the top module owns the flops and the
// reset/clear priority.
//
// Parameters:
//   WIDTH     register width (>= 2)
//   SATURATE  0 = INC/DEC wrap, 1 = INC/DEC stick at the bounds
// Ports:
//   mode_i  in   operation code
//   data_i  in   current register contents
//   cy_i    in   current carry flag (needed so HOLD keeps it)
//   load_i  in   parallel load data
//   ser_i   in   serial input bit for SHL/SHR
//   data_o  out  next register contents
//   cy_o    out  next carry/borrow/shifted-out flag
module reg_univ_next
  import reg_univ_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              cy_i,
  input  logic [WIDTH-1:0]  load_i,
  input  logic              ser_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              cy_o
);

  // Arithmetic is done one bit wider; the extra MSB is the carry (INC)
  // or the borrow (DEC), which is set exactly at all-ones / zero.
  logic [WIDTH:0] inc_s;
  logic [WIDTH:0] dec_s;

  assign inc_s = {1'b0, data_i} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s = {1'b0, data_i} - {{WIDTH{1'b0}}, 1'b1};

  // Select the next value and flag for the current operation code.
  always_comb begin
    data_o = data_i;
    cy_o   = cy_i;
    case (mode_i)
      MODE_HOLD: begin
        data_o = data_i;
        cy_o   = cy_i;
      end
      MODE_LOAD: begin
        data_o = load_i;
        cy_o   = 1'b0;
      end
      MODE_SHL: begin
        data_o = {data_i[WIDTH-2:0], ser_i};
        cy_o   = data_i[WIDTH-1];
      end
      MODE_SHR: begin
        data_o = {ser_i, data_i[WIDTH-1:1]};
        cy_o   = data_i[0];
      end
      MODE_ROL: begin
        data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        cy_o   = data_i[WIDTH-1];
      end
      MODE_ROR: begin
        data_o = {data_i[0], data_i[WIDTH-1:1]};
        cy_o   = data_i[0];
      end
      MODE_INC: begin
        // Flag is the carry in both flavours; saturation only freezes data.
        cy_o = inc_s[WIDTH];
        if (SATURATE && inc_s[WIDTH]) begin
          data_o = data_i;
        end else begin
          data_o = inc_s[WIDTH-1:0];
        end
      end
      MODE_DEC: begin
        cy_o = dec_s[WIDTH];
        if (SATURATE && dec_s[WIDTH]) begin
          data_o = data_i;
        end else begin
          data_o = dec_s[WIDTH-1:0];
        end
      end
      default: begin
        data_o = data_i;
        cy_o   = cy_i;
      end
    endcase
  end

endmodule : reg_univ_next

// File: rtl/reg_univ.sv
// reg_univ -- parametrised universal register: hold, load, shift, rotate,
// increment and decrement under a 3-bit mode code, with synchronous clear,
// serial in for chaining and a registered carry/borrow flag.
//
// Parameters:
//   WIDTH     register width in bits (>= 2)
//   RST_VAL   data_out value after asynchronous reset
//   SATURATE  0 = INC/DEC wrap, 1 = INC/DEC stop at the bounds
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear, overrides mode
//   mode      in   operation code (see reg_univ_pkg)
//   data_in   in   parallel load data
//   ser_in    in   serial input bit for SHL/SHR
//   data_out  out  register contents (registered)
//   cy        out  carry/borrow/shifted-out flag (registered)
//   zero      out  data_out == 0, decoded directly from the register
module reg_univ
  import reg_univ_pkg::*;
#(
  parameter int             WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter bit             SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              cy,
  output logic              zero
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             cy_q;
  logic             cy_d;

  reg_univ_next #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .mode_i (mode),
    .data_i (data_q),
    .cy_i   (cy_q),
    .load_i (data_in),
    .ser_i  (ser_in),
    .data_o (data_d),
    .cy_o   (cy_d)
  );

  // State flops: async reset first, then synchronous clear, then the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_VAL;
      cy_q   <= 1'b0;
    end else if (clr) begin
      data_q <= {WIDTH{1'b0}};
      cy_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      cy_q   <= cy_d;
    end
  end

  assign data_out = data_q;
  assign cy       = cy_q;
  // Decoded from the flop outputs so it tracks data_out with no extra cycle.
  assign zero     = (data_q == {WIDTH{1'b0}});

endmodule : reg_univ

// File: tb/tb_reg_univ.sv
// tb_reg_univ -- self-checking bench for reg_univ.
// Four instances (WIDTH = 8, RST_VAL = 8'hA5): a wrapping one and a
// saturating one sharing the same stimulus, plus a two-stage chained
// serialiser (B.ser_in = A.data_out[7]). Every output is compared each
// cycle against an integer-arithmetic reference model.
module tb_reg_univ;
  import reg_univ_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [2:0] mode;
  logic [2:0] mode_c;
  logic [7:0] data_in;
  logic [7:0] din_a;
  logic [7:0] din_b;
  logic       ser_in;
  logic       ser_a;
  logic       ser_b;

  logic [7:0] dout_w, dout_s, dout_a, dout_b;
  logic       cy_w, cy_s, cy_a, cy_b;
  logic       zero_w, zero_s, zero_a, zero_b;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: value and flag per instance.
  int m_w, c_w, m_s, c_s, m_a, c_a, m_b, c_b;

  always #5 clk = ~clk;

  assign ser_b = dout_a[7];

  reg_univ #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .data_in(data_in),
    .ser_in(ser_in), .data_out(dout_w), .cy(cy_w), .zero(zero_w));

  reg_univ #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .data_in(data_in),
    .ser_in(ser_in), .data_out(dout_s), .cy(cy_s), .zero(zero_s));

  reg_univ #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode_c), .data_in(din_a),
    .ser_in(ser_a), .data_out(dout_a), .cy(cy_a), .zero(zero_a));

  reg_univ #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode_c), .data_in(din_b),
    .ser_in(ser_b), .data_out(dout_b), .cy(cy_b), .zero(zero_b));

  // Behavioural rule for one operation on an 8-bit unsigned value.
  function automatic void ref_next(input int md, input bit sat, input int din,
                                   input int ser, inout int v, inout int c);
    int o;
    o = v;
    case (md)
      0: begin end
      1: begin v = din; c = 0; end
      2: begin c = o / 128; v = (o * 2) % 256 + ser; end
      3: begin c = o % 2;   v = o / 2 + ser * 128; end
      4: begin c = o / 128; v = (o * 2) % 256 + o / 128; end
      5: begin c = o % 2;   v = o / 2 + (o % 2) * 128; end
      6: if (o == 255) begin c = 1; v = sat ? 255 : 0; end
         else begin c = 0; v = o + 1; end
      7: if (o == 0) begin c = 1; v = sat ? 0 : 255; end
         else begin c = 0; v = o - 1; end
      default: begin end
    endcase
  endfunction

  task automatic reset_model();
    m_w = 165; c_w = 0; m_s = 165; c_s = 0;
    m_a = 165; c_a = 0; m_b = 165; c_b = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w.data", dout_w, m_w[7:0]); chk("w.cy", {7'b0, cy_w}, c_w[7:0]);
    chk("w.zero", {7'b0, zero_w}, (m_w == 0) ? 8'd1 : 8'd0);
    chk("s.data", dout_s, m_s[7:0]); chk("s.cy", {7'b0, cy_s}, c_s[7:0]);
    chk("s.zero", {7'b0, zero_s}, (m_s == 0) ? 8'd1 : 8'd0);
    chk("a.data", dout_a, m_a[7:0]); chk("a.cy", {7'b0, cy_a}, c_a[7:0]);
    chk("a.zero", {7'b0, zero_a}, (m_a == 0) ? 8'd1 : 8'd0);
    chk("b.data", dout_b, m_b[7:0]); chk("b.cy", {7'b0, cy_b}, c_b[7:0]);
    chk("b.zero", {7'b0, zero_b}, (m_b == 0) ? 8'd1 : 8'd0);
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    int sb;
    @(posedge clk);
    sb = m_a / 128;
    if (!rst_n) begin
      reset_model();
    end else if (clr) begin
      m_w = 0; c_w = 0; m_s = 0; c_s = 0; m_a = 0; c_a = 0; m_b = 0; c_b = 0;
    end else begin
      ref_next(int'(mode),   1'b0, int'(data_in), int'(ser_in), m_w, c_w);
      ref_next(int'(mode),   1'b1, int'(data_in), int'(ser_in), m_s, c_s);
      ref_next(int'(mode_c), 1'b0, int'(din_a),   int'(ser_a),  m_a, c_a);
      ref_next(int'(mode_c), 1'b0, int'(din_b),   sb,           m_b, c_b);
    end
    #1;
    check_all();
  endtask

  // Async reset pulse placed between edges; outputs must react at once.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 reset_model();
    check_all();
    chk("async_rst.data", dout_w, 8'hA5);
    chk("async_rst.cy", {7'b0, cy_w}, 8'h00);
    #1 rst_n = 1'b1;
  endtask

  task automatic shift_case(input string tag, input logic [2:0] m, input logic s,
                            input logic [7:0] exp, input logic exp_cy);
    mode = MODE_LOAD; data_in = 8'h81; tick();
    mode = m; ser_in = s; tick();
    chk(tag, dout_w, exp);
    chk(tag, {7'b0, cy_w}, {7'b0, exp_cy});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; mode = MODE_HOLD; mode_c = MODE_HOLD;
    data_in = 8'h00; din_a = 8'h00; din_b = 8'h00; ser_in = 1'b0; ser_a = 1'b0;
    reset_model();
    #12;
    check_all();
    chk("reset.data", dout_w, 8'hA5);
    rst_n = 1'b1;

    // Reset arriving in the middle of an INC run.
    mode = MODE_INC; tick(); tick();
    chk("inc.a7", dout_w, 8'hA7);
    async_reset();

    // Clear beats LOAD on the same edge.
    clr = 1'b1; mode = MODE_LOAD; data_in = 8'h3C; tick();
    chk("clr.data", dout_w, 8'h00);
    chk("clr.zero", {7'b0, zero_w}, 8'h01);
    clr = 1'b0;

    // Load then hold.
    mode = MODE_LOAD; data_in = 8'h81; tick();
    chk("load.data", dout_w, 8'h81);
    mode = MODE_HOLD;
    repeat (5) tick();
    chk("hold.data", dout_w, 8'h81);

    shift_case("shl", MODE_SHL, 1'b0, 8'h02, 1'b1);
    shift_case("shr", MODE_SHR, 1'b1, 8'hC0, 1'b1);
    shift_case("rol", MODE_ROL, 1'b0, 8'h03, 1'b1);
    shift_case("ror", MODE_ROR, 1'b0, 8'hC0, 1'b1);

    // Wrap-around on the non-saturating instance.
    mode = MODE_LOAD; data_in = 8'hFE; tick();
    mode = MODE_INC; tick();
    chk("wrap.ff", dout_w, 8'hFF); chk("wrap.ff.cy", {7'b0, cy_w}, 8'h00);
    tick();
    chk("wrap.00", dout_w, 8'h00); chk("wrap.00.cy", {7'b0, cy_w}, 8'h01);
    chk("wrap.00.zero", {7'b0, zero_w}, 8'h01);
    mode = MODE_DEC; tick();
    chk("wrap.dec", dout_w, 8'hFF); chk("wrap.dec.cy", {7'b0, cy_w}, 8'h01);

    // Saturation bounds on the saturating instance.
    mode = MODE_LOAD; data_in = 8'hFF; tick();
    mode = MODE_INC; tick();
    chk("sat.ff", dout_s, 8'hFF); chk("sat.ff.cy", {7'b0, cy_s}, 8'h01);
    mode = MODE_LOAD; data_in = 8'h00; tick();
    mode = MODE_DEC;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat.00", dout_s, 8'h00); chk("sat.00.cy", {7'b0, cy_s}, 8'h01);
    end
    mode = MODE_INC; tick();
    chk("sat.01", dout_s, 8'h01); chk("sat.01.cy", {7'b0, cy_s}, 8'h00);

    // Chained serialiser: A shifts into B.
    mode = MODE_HOLD;
    mode_c = MODE_LOAD; din_a = 8'hF0; din_b = 8'h00; tick();
    mode_c = MODE_SHL; ser_a = 1'b0;
    repeat (8) tick();
    chk("chain.b", dout_b, 8'hF0);
    chk("chain.a", dout_a, 8'h00);

    // Randomised operation mix, including clears and one async reset.
    for (int i = 0; i < 300; i++) begin
      mode    = 3'($urandom_range(0, 7));
      mode_c  = 3'($urandom_range(0, 7));
      data_in = 8'($urandom);
      din_a   = 8'($urandom);
      din_b   = 8'($urandom);
      ser_in  = 1'($urandom_range(0, 1));
      ser_a   = 1'($urandom_range(0, 1));
      clr     = ($urandom_range(0, 15) == 0);
      tick();
      if (i == 150) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_univ
